// File: rtl/keypad_pkg.sv
// Shared types and elaboration helpers for the matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [0:0] {
    StSettle,
    StCommit
  } scan_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A queued event is {code, press}.
  function automatic int unsigned event_width(input int unsigned keys);
    return idx_width(keys) + 1;
  endfunction

  function automatic bit params_legal(input int unsigned rows, input int unsigned cols,
                                      input int unsigned scan_div,
                                      input int unsigned debounce_scans,
                                      input int unsigned fifo_depth);
    return (rows >= 1) && (rows <= 8) && (cols >= 1) && (cols <= 8) && (scan_div >= 2) &&
           (debounce_scans >= 1) && (fifo_depth >= 2) &&
           ((fifo_depth & (fifo_depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous FIFO holding key events; push and pop may share a cycle.
module key_event_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop    = pop && !empty;
  // A pop frees the head slot, so a push into a full FIFO is accepted alongside it.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  // Storage and pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Column-scanning keypad matrix reader with per-key debounce and an event FIFO.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  localparam int unsigned CW            = idx_width(ROWS * COLS)
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic [ROWS-1:0]      row_n,
  output logic [COLS-1:0]      col_n,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [CW-1:0]        key_code,
  output logic                 key_press,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 overflow,
  input  logic                 ov_clr
);

  localparam int unsigned KEYS = ROWS * COLS;
  localparam int unsigned RW   = idx_width(ROWS);
  localparam int unsigned CLW  = idx_width(COLS);
  localparam int unsigned DW   = $clog2(SCAN_DIV);
  localparam int unsigned NW   = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned EW   = event_width(KEYS);

  if (!params_legal(ROWS, COLS, SCAN_DIV, DEBOUNCE_SCANS, FIFO_DEPTH)) begin : g_param_check
    $error("keypad_matrix_scanner: illegal parameter set");
  end

  logic [ROWS-1:0] row_meta_q, row_sync_q, sample_q;
  scan_state_e     state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [CLW-1:0]  col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            latch;
  logic [NW-1:0]   cnt_q [KEYS];
  logic [NW-1:0]   cnt_cur, cnt_d;
  logic [KEYS-1:0] key_state_q;
  logic [CW-1:0]   key_idx;
  logic            sample_bit, stable_bit, flip, push, pop, fifo_full, fifo_empty;
  logic            overflow_q, drop;
  logic [EW-1:0]   head;

  // Two-flop synchronizer on the asynchronous row inputs; idle rows read high.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
    end
  end

  // Scan sequencer state registers.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= StSettle;
      div_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      sample_q <= '1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (latch) sample_q <= row_sync_q;
    end
  end

  // Settle on a column, latch its rows, then walk the rows one per cycle.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    col_d   = col_q;
    row_d   = row_q;
    latch   = 1'b0;
    unique case (state_q)
      StSettle: begin
        if (div_q == DW'(SCAN_DIV - 1)) begin
          latch   = 1'b1;
          div_d   = '0;
          row_d   = '0;
          state_d = StCommit;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StCommit: begin
        if (row_q == RW'(ROWS - 1)) begin
          row_d   = '0;
          col_d   = (col_q == CLW'(COLS - 1)) ? '0 : col_q + 1'b1;
          state_d = StSettle;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      default: state_d = StSettle;
    endcase
  end

  // Columns idle high while reset is held, so nothing is driven before scanning starts.
  assign col_n = sys_rst ? '1 : ~(COLS'(1) << col_q);

  assign key_idx    = CW'(int'(row_q) * int'(COLS) + int'(col_q));
  assign sample_bit = ~sample_q[row_q];
  assign stable_bit = key_state_q[key_idx];
  assign cnt_cur    = cnt_q[key_idx];

  // Debounce step for the key addressed this cycle.
  always_comb begin
    cnt_d = '0;
    flip  = 1'b0;
    if (sample_bit != stable_bit) begin
      if (cnt_cur == NW'(DEBOUNCE_SCANS - 1)) flip = 1'b1;
      else                                    cnt_d = cnt_cur + 1'b1;
    end
  end

  assign push = (state_q == StCommit) && flip;

  // Per-key counters and stable state; only the addressed key changes.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      key_state_q <= '0;
      for (int k = 0; k < int'(KEYS); k++) cnt_q[k] <= '0;
    end else if (state_q == StCommit) begin
      cnt_q[key_idx] <= cnt_d;
      if (flip) key_state_q[key_idx] <= sample_bit;
    end
  end

  assign pop  = key_valid && key_ready;
  assign drop = push && fifo_full && !pop;

  key_event_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (sys_rst),
    .push     (push),
    .push_data({key_idx, sample_bit}),
    .pop      (pop),
    .head_data(head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst)     overflow_q <= 1'b0;
    else if (drop)   overflow_q <= 1'b1;
    else if (ov_clr) overflow_q <= 1'b0;
  end

  assign key_valid = ~fifo_empty;
  assign key_code  = head[EW-1:1];
  assign key_press = head[0];
  assign key_state = key_state_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural 4x4 key matrix.
module tb_keypad_matrix_scanner;

  localparam int FRAME = 48;

  logic        clk = 1'b0;
  logic        sys_rst, key_ready, ov_clr;
  logic [3:0]  row_n, col_n, key_code;
  logic        key_valid, key_press, overflow;
  logic [15:0] key_state;
  logic [15:0] held;
  int          n_checks = 0;
  int          n_fail = 0;
  int          w;
  int          ev_cnt;
  logic [3:0]  exp_col;

  always #5 clk = ~clk;

  // Closed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  keypad_matrix_scanner #(
    .ROWS          (4),
    .COLS          (4),
    .SCAN_DIV      (8),
    .DEBOUNCE_SCANS(3),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_code (key_code),
    .key_press(key_press),
    .key_state(key_state),
    .overflow (overflow),
    .ov_clr   (ov_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget, output int waited);
    waited = 0;
    while (key_valid !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, 32'(key_valid), 32'd1);
  endtask

  task automatic pop_expect(input string tag, input int code, input logic press);
    check({tag, "_code"}, 32'(key_code), 32'(code));
    check({tag, "_press"}, 32'(key_press), 32'(press));
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic drain(input int cycles);
    key_ready = 1'b1;
    repeat (cycles) @(negedge clk);
    key_ready = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    held = '0; key_ready = 1'b0; ov_clr = 1'b0; sys_rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col_n", 32'(col_n), 32'hF);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_state", 32'(key_state), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);

    // Column walk: each column driven for 12 cycles, two full frames.
    sys_rst = 1'b0;
    #1;
    for (int i = 0; i < 96; i++) begin
      exp_col = ~(4'b0001 << ((i / 12) % 4));
      check("col_walk", 32'(col_n), 32'(exp_col));
      @(negedge clk);
      #1;
    end
    @(negedge clk);

    // Single key 9 (row 2, column 1): press then release.
    held[9] = 1'b1;
    wait_valid("press9", 200, w);
    check("press9_latency", 32'(w >= 96 && w <= 170), 32'd1);
    check("press9_state", 32'(key_state), 32'h0200);
    pop_expect("press9", 9, 1'b1);
    check("press9_single", 32'(key_valid), 32'd0);
    ev_cnt = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (key_valid) ev_cnt++;
    end
    check("press9_no_extra", 32'(ev_cnt), 32'd0);
    held[9] = 1'b0;
    wait_valid("rel9", 200, w);
    check("rel9_state", 32'(key_state), 32'h0000);
    pop_expect("rel9", 9, 1'b0);

    // Bounce: alternate frames never reach three consecutive differing samples.
    ev_cnt = 0;
    for (int f = 0; f < 6; f++) begin
      held[9] = (f % 2 == 0);
      repeat (FRAME) begin
        @(negedge clk);
        if (key_valid) ev_cnt++;
      end
    end
    held[9] = 1'b0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (key_valid) ev_cnt++;
    end
    check("bounce_events", 32'(ev_cnt), 32'd0);
    check("bounce_state", 32'(key_state), 32'h0000);

    // Rows 0 and 3 of column 1 together: ascending row order.
    held = 16'h2002;
    wait_valid("samecol", 200, w);
    repeat (6) @(negedge clk);
    pop_expect("samecol_first", 1, 1'b1);
    check("samecol_second_valid", 32'(key_valid), 32'd1);
    pop_expect("samecol_second", 13, 1'b1);
    check("samecol_empty", 32'(key_valid), 32'd0);
    held = '0;
    drain(4 * FRAME);
    check("samecol_released", 32'(key_state), 32'h0000);

    // Overflow: align to the start of column 0, then press five keys at once.
    w = 0;
    while (col_n !== 4'b0111 && w < 100) begin @(negedge clk); w++; end
    while (col_n !== 4'b1110 && w < 100) begin @(negedge clk); w++; end
    check("ov_align", 32'(col_n), 32'hE);
    held = 16'h8431;
    repeat (4 * FRAME) @(negedge clk);
    check("ov_flag", 32'(overflow), 32'd1);
    check("ov_state", 32'(key_state), 32'h8431);
    pop_expect("ov_pop0", 0, 1'b1);
    pop_expect("ov_pop1", 4, 1'b1);
    pop_expect("ov_pop2", 5, 1'b1);
    pop_expect("ov_pop3", 10, 1'b1);
    check("ov_drained", 32'(key_valid), 32'd0);
    check("ov_sticky", 32'(overflow), 32'd1);
    ov_clr = 1'b1;
    @(negedge clk);
    ov_clr = 1'b0;
    check("ov_cleared", 32'(overflow), 32'd0);
    held = '0;
    drain(4 * FRAME);
    check("ov_release_no_drop", 32'(overflow), 32'd0);
    check("ov_release_state", 32'(key_state), 32'h0000);

    // Reset mid-run with events queued and key 9 held.
    held = 16'h4200;
    wait_valid("mid", 200, w);
    repeat (FRAME) @(negedge clk);
    held = 16'h0200;
    sys_rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(key_valid), 32'd0);
    check("mid_rst_col_n", 32'(col_n), 32'hF);
    check("mid_rst_state", 32'(key_state), 32'h0000);
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    wait_valid("rearm", 200, w);
    check("rearm_latency", 32'(w >= 96 && w <= 170), 32'd1);
    check("rearm_state", 32'(key_state), 32'h0200);
    pop_expect("rearm", 9, 1'b1);
    held = '0;
    drain(4 * FRAME);
    check("final_state", 32'(key_state), 32'h0000);
    check("final_valid", 32'(key_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Parametrised matrix-keypad scanner, the successor to the fixed 4x4 keypad decoder. It drives an R x C key matrix one column at a time and debounces every key independently. Press and release events go into a small FIFO with a valid/ready handshake, and a live key-state bitmap is also provided. It sits between the keypad pins and consumers such as the LED display, running on the 100 MHz PLL clock.

## Interface
Parameters:
- ROWS, 4: number of matrix rows (row inputs), 1..8
- COLS, 4: number of matrix columns (column drive outputs), 1..8
- SCAN_DIV, 1000: settle cycles per column before sampling; must be ≥ 2
- DEBOUNCE_SCANS, 4: consecutive differing samples of a key required to change its stable state; must be ≥ 1
- FIFO_DEPTH, 4: event FIFO entries; must be a power of 2, ≥ 2

Ports:
- clk  in  1  system clock; the only clock
- sys_rst  in  1  reset, asynchronous and active-high
- row_n  in  ROWS  matrix row inputs, active-low (low = key closed in the driven column), asynchronous
- col_n  out  COLS  column drive, one-hot active-low
- key_valid  out  1  FIFO head holds an event
- key_ready  in  1  consumer accepts the head event
- key_code  out  CW  key index, row*COLS+col, with CW = clog2(ROWS*COLS)
- key_press  out  1  1 = press event, 0 = release event
- key_state  out  ROWS*COLS  debounced stable state; bit k = 1 means key k is held
- overflow  out  1  sticky flag: an event was dropped
- ov_clr  in  1  synchronous clear of overflow

## Operation
- row_n passes through a 2-flop synchronizer before any use.
- Scan FSM:
  - SETTLE: drive column c low and count SCAN_DIV cycles. In the last cycle, latch the synchronized row vector.
  - COMMIT: walk r = 0..ROWS-1, one row per cycle, processing key (r, c).
  - After row ROWS-1, c wraps (COLS-1 → 0) and the FSM returns to SETTLE.
  - col_n stays on column c through COMMIT.
  - Column period is SCAN_DIV+ROWS cycles; frame period is COLS times that.
- Per-key debounce, done in COMMIT:
  - sample == stable: the key's counter is cleared.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_SCANS: stable flips, the counter clears, and an event {code, press=new stable} is pushed.
- FIFO behaviour:
  - A pop occurs when key_valid && key_ready.
  - A push when full with no pop in the same cycle drops the event and sets overflow. key_state still updates.
  - A push and pop in the same cycle when full are both accepted.
  - No empty bypass: a pushed event is visible on the cycle after the push.
  - key_code and key_press are stable while key_valid=1 and key_ready=0.
- overflow: if ov_clr and a new drop occur in the same cycle, the drop wins and overflow stays 1.
- Ghosting: no anti-ghosting; phantom keys are reported as sampled.

## Timing
- Reset values (asynchronous):
  - col_n = all ones; key_valid = 0; key_code = 0; key_press = 0; key_state = 0; overflow = 0.
  - FSM in SETTLE with c = 0; all counters and FIFO pointers zero.
- First cycle after reset deassertion: col_n = ~1 (column 0 driven).
- Reset mid-operation discards FIFO contents and stable states. Keys held across reset are reported again as presses after DEBOUNCE_SCANS frames.
- Event latency:
  - Pushed in the COMMIT cycle of its row.
  - key_valid rises the next cycle if the FIFO was empty.
  - Pin to key_valid ≤ 2 (sync) + DEBOUNCE_SCANS frames + 1 cycle.
- Multiple keys flipping in one column: events are ordered by ascending row, in consecutive cycles.
- key_state bit changes in the same cycle as the push.

## Structure
- Package keypad_pkg holds:
  - scan state enum (SETTLE, COMMIT)
  - event struct/width {code, press}
  - clog2-based CW helper and parameter-legality checks
- Sub-module key_event_fifo: synchronous FIFO, parametrised width and depth, with full/empty flags and simultaneous push/pop. Instantiated once.
- Debounce counters are an array in the top module, indexed by key code. They are updated only for the single key addressed in COMMIT.

## Test plan
All scenarios use ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE_SCANS=3, FIFO_DEPTH=4. Column period = 12 cycles, frame = 48 cycles.
- Reset/scan: hold sys_rst → col_n=1111, key_valid=0. Release → col_n cycles 1110, 1101, 1011, 0111, each for exactly 12 cycles, then repeats.
- Single key: hold row 2 at column 1 → exactly one event, code 9 with press=1, after the 3rd frame; key_state[9]=1. Release → one event, code 9 with press=0, after 3 frames.
- Bounce: toggle key 9 pressed/released on alternate frames for 6 frames → no events, key_state[9] stays 0.
- Same column: rows 0 and 3 pressed at column 1 together → events code 1 then code 13, in consecutive cycles.
- Overflow: key_ready=0, then debounce 5 distinct key presses → 4 events retained in order, overflow=1, key_state has 5 bits set. Drain with key_ready=1 → 4 pops. Pulse ov_clr → overflow=0.
- Reset mid-run: 2 events queued and key 9 held, assert sys_rst → key_valid=0, col_n=1111, key_state=0. After release, code 9 with press=1 is re-reported after 3 frames.
